// File: rtl/ftdi_pkg.sv
// ftdi_pkg: definitions shared by the FTDI UART receiver and transmitter.
// Holds the 3-bit state encoding, the default oversampling ratio, the
// byte width and a helper that computes the tick divider.
package ftdi_pkg;

  localparam int BYTE_W             = 8;
  localparam int DEFAULT_OVERSAMPLE = 16;

  // State encoding, kept as plain localparams so the transmitter and any
  // debug tooling can decode the state bus without the enum type.
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = IDLE,
    ST_START = START,
    ST_DATA  = DATA,
    ST_STOP  = STOP,
    ST_BREAK = BREAK
  } rx_state_e;

  // Clock cycles per sample tick, truncated, never below 1.
  function automatic int calc_div(input int freq, input int baud, input int os);
    int d;
    d = freq / (baud * os);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/ftdi_rx_if.sv
// ftdi_rx_if: byte delivery handshake between the UART receiver and its
// consumer, plus status flags and a state debug bus.
//   data          : last received byte
//   done          : byte available, held until ack
//   ack           : consumer took data (only meaningful while done=1)
//   busy          : a frame is in progress
//   framing_error : sticky, last frame had a low stop bit
//   overrun       : sticky, a byte was dropped because done was still set
//   state_dbg     : receiver FSM state (ftdi_pkg encoding)
// Handshake: done is a level; the first clock edge with done=1 and ack=1
// consumes the byte. ack may stay high longer; it has no effect while done=0.
// master = receiver side, slave = consumer side.
interface ftdi_rx_if;
  import ftdi_pkg::*;

  logic [BYTE_W-1:0] data;
  logic              done;
  logic              ack;
  logic              busy;
  logic              framing_error;
  logic              overrun;
  logic [2:0]        state_dbg;

  modport master (
    output data, done, busy, framing_error, overrun, state_dbg,
    input  ack
  );

  modport slave (
    input  data, done, busy, framing_error, overrun, state_dbg,
    output ack
  );
endinterface

// File: rtl/uart_tick_gen.sv
// uart_tick_gen: divide-by-DIV counter that emits a 1-cycle tick.
//   clk, reset_n : clock, async active-low reset
//   clear        : restart the phase; no tick is emitted in a clear cycle
//   tick         : one-cycle pulse every DIV clocks
module uart_tick_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = !clear && (cnt == LAST);
endmodule

// File: rtl/ftdi_rx.sv
// ftdi_rx: 16x oversampling UART receiver for the host-to-FPGA FTDI link.
//   clk, reset_n : clock, async active-low reset
//   FTDI_TX      : serial line from the host, idle high, asynchronous
//   bus          : ftdi_rx_if.master (data/done/ack handshake, flags, debug)
// Start bit is re-checked at mid-bit, data bits are sampled every
// OVERSAMPLE ticks from there, LSB first. A low stop bit sets the sticky
// framing error and parks the FSM in BREAK until the line goes high.
module ftdi_rx
  import ftdi_pkg::*;
#(
  parameter int FREQUENCY  = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       FTDI_TX,
  ftdi_rx_if.master  bus
);
  localparam int DIV  = calc_div(FREQUENCY, BAUD_RATE, OVERSAMPLE);
  localparam int SW   = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] BIT_LAST  = SW'(OVERSAMPLE - 1);

  logic              rx_meta, rx;
  rx_state_e         state;
  logic [SW-1:0]     sub_cnt;
  logic [2:0]        bit_idx;
  logic [BYTE_W-1:0] shreg;
  logic [BYTE_W-1:0] data_q;
  logic              done_q, fe_q, ov_q;
  logic              tick, tick_clear, ack_take;

  // Synchronizer flops reset high so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx      <= 1'b1;
    end else begin
      rx_meta <= FTDI_TX;
      rx      <= rx_meta;
    end
  end

  // Realign the tick phase to the detected start edge.
  assign tick_clear = (state == ST_IDLE) && !rx;

  uart_tick_gen #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (tick_clear),
    .tick    (tick)
  );

  assign ack_take = done_q && bus.ack;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      sub_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      // Acknowledge clears first; a delivery or new error in the same cycle
      // is assigned later and takes precedence.
      if (ack_take) begin
        done_q <= 1'b0;
        fe_q   <= 1'b0;
        ov_q   <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (!rx) begin
            state   <= ST_START;
            sub_cnt <= '0;
          end
        end
        ST_START: begin
          if (tick) begin
            if (sub_cnt == HALF_LAST) begin
              sub_cnt <= '0;
              bit_idx <= '0;
              state   <= rx ? ST_IDLE : ST_DATA;
            end else begin
              sub_cnt <= sub_cnt + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (sub_cnt == BIT_LAST) begin
              sub_cnt <= '0;
              shreg   <= {rx, shreg[BYTE_W-1:1]};
              bit_idx <= bit_idx + 1'b1;
              if (bit_idx == 3'(BYTE_W - 1)) state <= ST_STOP;
            end else begin
              sub_cnt <= sub_cnt + 1'b1;
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (sub_cnt == BIT_LAST) begin
              sub_cnt <= '0;
              if (rx) begin
                // Leaving at mid-stop leaves half a bit to catch the next start edge.
                state <= ST_IDLE;
                if (!done_q || bus.ack) begin
                  data_q <= shreg;
                  done_q <= 1'b1;
                end else begin
                  ov_q <= 1'b1;
                end
              end else begin
                fe_q  <= 1'b1;
                state <= ST_BREAK;
              end
            end else begin
              sub_cnt <= sub_cnt + 1'b1;
            end
          end
        end
        ST_BREAK: begin
          if (rx) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.data          = data_q;
  assign bus.done          = done_q;
  assign bus.busy          = (state != ST_IDLE);
  assign bus.framing_error = fe_q;
  assign bus.overrun       = ov_q;
  assign bus.state_dbg     = state;
endmodule

// File: doc/ftdi_rx.md
# ftdi_rx

UART receiver for the host-to-FPGA direction of the FTDI link. It samples the `FTDI_TX` line with 16x oversampling and validates start and stop bits. Each good byte is presented on a held `data`/`done` pair that stays up until the consumer acknowledges it. It sits beside the FTDI transmitter in the top level and feeds host commands, such as sensor selection and measurement requests, to the control FSM.

## Interface
- `FREQUENCY`, 50_000_000, system clock frequency in Hz.
- `BAUD_RATE`, 115200, line bit rate.
- `OVERSAMPLE`, 16, sample ticks per bit. Must be even and ≥ 4.
- `clk`  in  1  system clock. All logic is on the rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low. One clock domain.
- `FTDI_TX`  in  1  serial line from the host. Idle high. Asynchronous to `clk`.
- `ack`  in  1  consumer has taken `data`. Sampled only while `done`=1.
- `data`  out  8  last received byte, LSB-first on the wire.
- `done`  out  1  byte available. Held until `ack`.
- `busy`  out  1  a frame is in progress (state ≠ IDLE).
- `framing_error`  out  1  sticky. The last frame had a low stop bit.
- `overrun`  out  1  sticky. A byte was dropped because `done` was still set.

## Operation
- Input path: 2-FF synchronizer on `FTDI_TX`, with both flops reset to 1. All logic uses the synchronized `rx`.
- Tick generator: a divider of `DIV = FREQUENCY/(BAUD_RATE*OVERSAMPLE)`, truncated, minimum 1. It emits a 1-cycle `tick`.
  - Free-running in IDLE.
  - Phase counter cleared on start-edge detection.
- States:
  - **IDLE**: on `rx`=0, go to START and clear the sub-bit tick count.
  - **START**: after `OVERSAMPLE/2` ticks, re-sample `rx`.
    - If `rx`=1, treat it as a glitch and return to IDLE with no flags.
    - Else go to DATA with the bit index at 0.
  - **DATA**: every `OVERSAMPLE` ticks, shift `rx` into the shift register MSB, so bit 0 arrives first. After 8 samples, go to STOP.
  - **STOP**: after `OVERSAMPLE` ticks, sample `rx`.
    - If `rx`=1, deliver the byte (see below) and go to IDLE.
    - If `rx`=0, set `framing_error`, discard the byte and go to BREAK.
  - **BREAK**: wait for `rx`=1, then go to IDLE. This stops a held-low line from generating repeated frames.
- Delivery:
  - If `done`=0, or `ack`=1 in the same cycle: load `data` and set `done`=1.
  - Else: keep the old `data`, set `overrun`, drop the new byte.
- Acknowledge:
  - `ack`=1 while `done`=1 clears `done`, `overrun` and `framing_error` on the next edge.
  - `ack` while `done`=0 is ignored. It does not clear the flags.
- `data` changes only on delivery. It is never modified while `done`=1 without `ack`.

## Timing
- Reset values: `data`=8'h00, `done`=0, `busy`=0, `framing_error`=0, `overrun`=0, state IDLE.
- Reset asserted mid-frame aborts immediately to those values. There is no partial delivery after release.
- Latency from the `FTDI_TX` falling edge to `done` rising: `2` (sync) `+ DIV*(OVERSAMPLE/2 + 9*OVERSAMPLE)` `+ 1` cycles, ±DIV for tick phase.
- `busy` rises 3 cycles after the line edge. It falls in the same cycle `done` rises, or when BREAK exits.
- Back-to-back frames (stop bit immediately followed by a start bit) are received without loss. IDLE is re-entered at mid-stop, before the next falling edge.
- `done` and `ack` follow a level/pulse handshake. `ack` may be held high for multiple cycles. Only the first cycle with `done`=1 has an effect.

## Structure
- Shared package `ftdi_pkg` holds:
  - state encoding `IDLE, START, DATA, STOP, BREAK` as 3-bit localparams;
  - the default `OVERSAMPLE`;
  - the byte width 8.
- The transmitter should adopt the same package.
- One sub-module, `uart_tick_gen`. It is a parameterized divider with `clear` and `tick`, and is reusable by the transmitter's baud generator.
- Everything else (FSM, shift register, flags) lives in `ftdi_rx`.

## Test plan
Bench parameters: `FREQUENCY`=16_000, `BAUD_RATE`=1000, `OVERSAMPLE`=16. This gives DIV=1 and 16 cycles per bit.
- Send 8'hA5 with a good stop bit, no `ack` → `data`=8'hA5 and `done`=1 at 2+8+144+1=155 cycles ±1 after the edge. `done` stays high for 100 cycles.
- Drive `FTDI_TX` low for 4 cycles, then high → no `done`, `busy` returns to 0, flags stay 0.
- Send 8'h3C with the stop bit low, line held low for 64 more cycles → `framing_error`=1 and `done`=0. A single BREAK pass, with no further frames, until the line goes high.
- Send 8'h11 then 8'h22 back-to-back, no `ack` → `data`=8'h11 and `overrun`=1. After `ack`: `done`=0 and `overrun`=0.
- Send 8'h11 and pulse `ack` on the exact cycle the 8'h22 stop sample delivers → `data`=8'h22, `done`=1, `overrun`=0.
- Assert `reset_n`=0 mid-DATA of 8'hFF → all outputs go to reset values. A fresh 8'h5A after release is received correctly.
